// File: rtl/vn_word_packer.sv
`timescale 1ns/1ps
// vn_word_packer
// Packs the debiased single-bit TRNG stream into WORD_W-bit words and offers
// them to the key/seed loader over a valid/ready handshake. The bit source
// cannot be stalled. A completed word that finds the output register still
// occupied is dropped and counted. Bits already packed are never altered.
//
// Build option:
//   TRNG_REP_TEST_EN - adds a repetition-count health test on the bit stream.
//                      Without it health_fail is constant 0.
//
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous, active-high; clears every register
//   bit_valid   - qualifies bit_in for one cycle
//   bit_in      - debiased random bit
//   word_valid  - word_data holds a complete word
//   word_ready  - consumer takes the word this cycle when word_valid=1
//   word_data   - packed word, first-received bit in the MSB
//   overflow    - sticky, at least one completed word was dropped
//   drop_cnt    - saturating count of dropped words
//   ovf_clr     - clears overflow, drop_cnt and health_fail
//   health_fail - sticky repetition-test failure
module vn_word_packer #(
   parameter int WORD_W     = 32,
   parameter int DROP_CNT_W = 8,
   parameter int REP_LIMIT  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bit_valid,
   input  logic                  bit_in,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic [WORD_W-1:0]     word_data,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   input  logic                  ovf_clr,
   output logic                  health_fail
);

   localparam int CNT_W = $clog2(WORD_W);

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

   hold_state_t state, state_next;

   // The shift register only needs WORD_W-1 bits: the final bit of a word
   // is taken straight from bit_in when the word completes.
   logic [WORD_W-2:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WORD_W-1:0] cw;
   logic              word_done;
   logic              rep_trip;
   logic              load_word;
   logic              drop;

   assign cw = {shreg, bit_in};

`ifdef TRNG_REP_TEST_EN
   localparam int RUN_W = $clog2(REP_LIMIT + 1);

   logic [RUN_W-1:0] rep_cnt;
   logic [RUN_W-1:0] run_len;
   logic             last_bit;
   logic             health_q;

   // Length of the current run of identical bits including this one. A
   // zero count means the run restarts here (after reset or a trip).
   always_comb begin
      run_len = RUN_W'(1);
      if (rep_cnt != '0 && bit_in == last_bit) begin
         run_len = rep_cnt + 1'b1;
      end
   end

   assign rep_trip = bit_valid && (run_len == RUN_W'(REP_LIMIT));

   // Run tracking and sticky failure flag. A trip takes priority over
   // ovf_clr so a failure in the clearing cycle is not lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_cnt  <= '0;
         last_bit <= 1'b0;
         health_q <= 1'b0;
      end else begin
         if (bit_valid) begin
            last_bit <= bit_in;
            rep_cnt  <= rep_trip ? '0 : run_len;
         end
         if (rep_trip) begin
            health_q <= 1'b1;
         end else if (ovf_clr) begin
            health_q <= 1'b0;
         end
      end
   end

   assign health_fail = health_q;
`else
   assign rep_trip    = 1'b0;
   // The repetition limit has no effect in this build.
   assign health_fail = 1'b0 & (REP_LIMIT == 0);
`endif

   // A word is complete on its last bit, unless that bit tripped the health
   // test, in which case the whole word is thrown away without counting.
   assign word_done = bit_valid && (bit_cnt == CNT_W'(WORD_W - 1)) && !rep_trip;

   // Holding-register control. With word_ready high in HOLD_FULL a new word
   // can replace the accepted one in the same cycle, so there is no bubble.
   always_comb begin
      state_next = state;
      load_word  = 1'b0;
      drop       = 1'b0;
      case (state)
         HOLD_EMPTY: begin
            if (word_done) begin
               load_word  = 1'b1;
               state_next = HOLD_FULL;
            end
         end
         HOLD_FULL: begin
            if (word_ready) begin
               if (word_done) begin
                  load_word = 1'b1;
               end else begin
                  state_next = HOLD_EMPTY;
               end
            end else if (word_done) begin
               drop = 1'b1;
            end
         end
         default: begin
            state_next = HOLD_EMPTY;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= HOLD_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Bit accumulator. A health-test trip discards the partial word,
   // including the bit that caused it.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (rep_trip) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (bit_valid) begin
         shreg <= cw[WORD_W-2:0];
         if (bit_cnt == CNT_W'(WORD_W - 1)) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   // Output word register. It only changes on a load, which keeps it stable
   // while the consumer is stalling.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_data <= '0;
      end else if (load_word) begin
         word_data <= cw;
      end
   end

   // Drop bookkeeping. A drop in the same cycle as ovf_clr wins, so the count
   // restarts at one rather than being lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (ovf_clr) begin
            drop_cnt <= DROP_CNT_W'(1);
         end else if (!(&drop_cnt)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end else if (ovf_clr) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

   assign word_valid = (state == HOLD_FULL);

endmodule

// File: tb/tb_vn_word_packer.sv
`timescale 1ns/1ps
// Directed testbench for vn_word_packer with WORD_W=8, DROP_CNT_W=4,
// REP_LIMIT=6. Inputs change 1ns after the rising edge and outputs are
// checked at the same point, well away from the next edge.
module tb_vn_word_packer;

   localparam int WORD_W     = 8;
   localparam int DROP_CNT_W = 4;
   localparam int REP_LIMIT  = 6;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  bit_valid;
   logic                  bit_in;
   logic                  word_valid;
   logic                  word_ready;
   logic [WORD_W-1:0]     word_data;
   logic                  overflow;
   logic [DROP_CNT_W-1:0] drop_cnt;
   logic                  ovf_clr;
   logic                  health_fail;

   int total = 0;
   int bad   = 0;

   logic [7:0] acc_q[$];

   vn_word_packer #(
      .WORD_W     (WORD_W),
      .DROP_CNT_W (DROP_CNT_W),
      .REP_LIMIT  (REP_LIMIT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bit_valid   (bit_valid),
      .bit_in      (bit_in),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .word_data   (word_data),
      .overflow    (overflow),
      .drop_cnt    (drop_cnt),
      .ovf_clr     (ovf_clr),
      .health_fail (health_fail)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Record every word the consumer takes, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset === 1'b0 && word_valid === 1'b1 && word_ready === 1'b1) begin
         acc_q.push_back(word_data);
      end
   end

   // Count one comparison and report it if the values differ.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Advance n rising edges and settle 1ns past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Send the low nbits of pattern MSB-first, one bit per cycle.
   task automatic applyStimulus(input logic [15:0] pattern, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         bit_valid = 1'b1;
         bit_in    = pattern[i];
         tick(1);
      end
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] b2;
      reset      = 1'b1;
      bit_valid  = 1'b0;
      bit_in     = 1'b0;
      word_ready = 1'b0;
      ovf_clr    = 1'b0;
      tick(2);
      reset = 1'b0;

      checkOutput("rst_valid", word_valid, 0);
      checkOutput("rst_data", word_data, 0);
      checkOutput("rst_ovf", overflow, 0);
      checkOutput("rst_drop", drop_cnt, 0);
      checkOutput("rst_health", health_fail, 0);

      // Gapped bits 1,0,1,1,0,0,1,0 -> B2, single-cycle valid pulse.
      $display("[TB] single gapped word");
      word_ready = 1'b1;
      acc_q.delete();
      b2 = 8'hB2;
      for (int i = 7; i >= 1; i--) begin
         applyStimulus({15'd0, b2[i]}, 1);
         tick(2);
      end
      checkOutput("b2_before_last", word_valid, 0);
      applyStimulus({15'd0, b2[0]}, 1);
      checkOutput("b2_valid", word_valid, 1);
      checkOutput("b2_data", word_data, 8'hB2);
      checkOutput("b2_ovf", overflow, 0);
      tick(1);
      checkOutput("b2_pulse_end", word_valid, 0);
      checkOutput("b2_acc_n", acc_q.size(), 1);
      checkOutput("b2_acc", acc_q[0], 8'hB2);

      // Two words on consecutive cycles.
      $display("[TB] streaming A5 3C");
      acc_q.delete();
      applyStimulus(16'hA53C, 16);
      checkOutput("s_valid", word_valid, 1);
      checkOutput("s_data", word_data, 8'h3C);
      tick(1);
      checkOutput("s_acc_n", acc_q.size(), 2);
      checkOutput("s_acc0", acc_q[0], 8'hA5);
      checkOutput("s_acc1", acc_q[1], 8'h3C);
      checkOutput("s_drop", drop_cnt, 0);

      // Stalled consumer: 11 held, 22 and 33 dropped.
      $display("[TB] stalled consumer");
      word_ready = 1'b0;
      acc_q.delete();
      applyStimulus(16'h1122, 16);
      applyStimulus(16'h0033, 8);
      checkOutput("st_valid", word_valid, 1);
      checkOutput("st_data", word_data, 8'h11);
      checkOutput("st_ovf", overflow, 1);
      checkOutput("st_drop", drop_cnt, 2);
      word_ready = 1'b1;
      tick(1);
      checkOutput("st_drained", word_valid, 0);
      checkOutput("st_acc_n", acc_q.size(), 1);
      checkOutput("st_acc", acc_q[0], 8'h11);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      checkOutput("clr_ovf", overflow, 0);
      checkOutput("clr_drop", drop_cnt, 0);

      // Accept and reload on the same edge: 44 taken, 55 loaded, no drop.
      $display("[TB] back-to-back reload");
      word_ready = 1'b0;
      acc_q.delete();
      applyStimulus(16'h0044, 8);
      applyStimulus(16'h002A, 7);
      word_ready = 1'b1;
      applyStimulus(16'h0001, 1);
      checkOutput("b2b_valid", word_valid, 1);
      checkOutput("b2b_data", word_data, 8'h55);
      checkOutput("b2b_drop", drop_cnt, 0);
      checkOutput("b2b_ovf", overflow, 0);
      checkOutput("b2b_acc_n", acc_q.size(), 1);
      checkOutput("b2b_acc", acc_q[0], 8'h44);
      tick(1);
      checkOutput("b2b_drained", word_valid, 0);
      checkOutput("b2b_acc1", acc_q[1], 8'h55);

      // 20 words into a stalled consumer: 19 drops saturate at F.
      $display("[TB] drop counter saturation");
      word_ready = 1'b0;
      for (int w = 0; w < 20; w++) begin
         applyStimulus((w % 2 == 0) ? 16'h0055 : 16'h00AA, 8);
      end
      checkOutput("sat_drop", drop_cnt, 4'hF);
      checkOutput("sat_ovf", overflow, 1);
      checkOutput("sat_data", word_data, 8'h55);
      // A drop in the clearing cycle wins.
      applyStimulus(16'h002A, 7);
      ovf_clr = 1'b1;
      applyStimulus(16'h0001, 1);
      ovf_clr = 1'b0;
      checkOutput("clrdrop_ovf", overflow, 1);
      checkOutput("clrdrop_cnt", drop_cnt, 1);
      checkOutput("clrdrop_data", word_data, 8'h55);
      word_ready = 1'b1;
      tick(1);
      checkOutput("sat_drained", word_valid, 0);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;

      // Reset in the middle of a word discards the partial bits.
      $display("[TB] reset mid-word");
      applyStimulus(16'h001F, 5);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checkOutput("mid_rst_valid", word_valid, 0);
      applyStimulus(16'h00C3, 8);
      checkOutput("mid_valid", word_valid, 1);
      checkOutput("mid_data", word_data, 8'hC3);
      tick(1);

      // Repetition health test.
      $display("[TB] repetition test");
      doReset();
`ifdef TRNG_REP_TEST_EN
      // 0 then six 1s: the sixth 1 trips the test and the partial is lost.
      applyStimulus(16'h003F, 7);
      checkOutput("rep_health", health_fail, 1);
      checkOutput("rep_no_word", word_valid, 0);
      applyStimulus(16'h005A, 8);
      checkOutput("rep_valid", word_valid, 1);
      checkOutput("rep_data", word_data, 8'h5A);
      checkOutput("rep_sticky", health_fail, 1);
      tick(1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      checkOutput("rep_clr", health_fail, 0);
`else
      applyStimulus(16'h007F, 8);
      checkOutput("rep_valid", word_valid, 1);
      checkOutput("rep_data", word_data, 8'h7F);
      checkOutput("rep_health", health_fail, 0);
      tick(1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
